// File: rtl/code_entry_collector_if.sv
// -----------------------------------------------------------------------------
// code_entry_collector_if
// Carries the finished code word from the code entry collector to the lock FSM
// under a valid/ack handshake.
//   code_out   : assembled code, right-aligned, first digit most significant
//   code_len   : number of digits held in code_out
//   code_valid : code presented, held until code_ack
//   code_ack   : consumer accepts the presented code
// master = collector (producer), slave = lock FSM (consumer).
// -----------------------------------------------------------------------------
interface code_entry_collector_if #(
   parameter int DIGITS  = 4,
   parameter int DIGIT_W = 4
);
   localparam int CODE_W = DIGITS * DIGIT_W;
   localparam int LEN_W  = $clog2(DIGITS + 1);

   logic [CODE_W-1:0] code_out;
   logic [LEN_W-1:0]  code_len;
   logic              code_valid;
   logic              code_ack;

   modport master (
      output code_out,
      output code_len,
      output code_valid,
      input  code_ack
   );

   modport slave (
      input  code_out,
      input  code_len,
      input  code_valid,
      output code_ack
   );
endinterface

// File: rtl/code_entry_collector.sv
// -----------------------------------------------------------------------------
// code_entry_collector
// Front-end input stage of the digital lock. Debounces the digit, enter and
// clear buttons, collects up to DIGITS nibbles from the switches and presents
// the finished code to the lock FSM over a valid/ack handshake.
//
// Ports:
//   clk        : system clock, all logic on posedge
//   rst_n      : asynchronous active-low reset
//   switches   : digit value, sampled on an accepted digit press
//   digit_btn  : raw "store digit" button
//   enter_btn  : raw confirm button
//   clear_btn  : raw clear button
//   cif        : code handshake (code_out, code_len, code_valid, code_ack)
//   busy       : high while collecting or presenting
//   overflow   : sticky, digit pressed with a full buffer; cleared on IDLE entry
//   timeout    : one-cycle pulse on auto-clear of an abandoned entry
//
// Optional feature macro: ENTRY_TIMEOUT_EN
//   defined   : an idle counter in COLLECT auto-clears the entry after
//               TIMEOUT_CYCLES cycles without a button event
//   undefined : no counter, COLLECT waits indefinitely, timeout tied low
// -----------------------------------------------------------------------------
module code_entry_collector #(
   parameter int DIGITS          = 4,
   parameter int DIGIT_W         = 4,
   parameter int DEBOUNCE_CYCLES = 15,
   parameter int TIMEOUT_CYCLES  = 15
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [DIGIT_W-1:0] switches,
   input  logic               digit_btn,
   input  logic               enter_btn,
   input  logic               clear_btn,
   code_entry_collector_if.master cif,
   output logic               busy,
   output logic               overflow,
   output logic               timeout
);

   localparam int CODE_W = DIGITS * DIGIT_W;
   localparam int LEN_W  = $clog2(DIGITS + 1);
   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DIGITS);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_PRESENT = 2'd2
   } state_t;

   // Button lanes: [0] digit, [1] enter, [2] clear
   logic [2:0]           raw_s;
   logic [2:0]           prev_r;
   logic [2:0][DB_W-1:0] db_cnt_r;
   logic [2:0]           at_max_r;
   logic [2:0]           ev_r;

   logic dig_ev_s;
   logic ent_ev_s;
   logic clr_ev_s;

   state_t            state_r;
   state_t            state_next_s;
   logic [CODE_W-1:0] digits_r;
   logic [CODE_W-1:0] digits_next_s;
   logic [LEN_W-1:0]  count_r;
   logic [LEN_W-1:0]  count_next_s;
   logic [CODE_W-1:0] code_r;
   logic [CODE_W-1:0] code_next_s;
   logic [LEN_W-1:0]  len_r;
   logic [LEN_W-1:0]  len_next_s;
   logic              valid_r;
   logic              valid_next_s;
   logic              ovf_r;
   logic              ovf_next_s;
   logic              busy_r;

`ifdef ENTRY_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] idle_r;
   logic [TMO_W-1:0] idle_next_s;
   logic             tmo_r;
   logic             tmo_next_s;
`endif

   assign raw_s = {clear_btn, enter_btn, digit_btn};

   // Debounce: count stable cycles per button and emit one registered pulse
   // the first cycle a pressed button has been stable for DEBOUNCE_CYCLES.
   // at_max_r remembers that the counter was already saturated, so a held
   // button never re-fires; a released button (prev_r=0) never fires.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_r   <= 3'b000;
         db_cnt_r <= '0;
         at_max_r <= 3'b000;
         ev_r     <= 3'b000;
      end else begin
         prev_r <= raw_s;
         for (int i = 0; i < 3; i++) begin
            if (raw_s[i] != prev_r[i]) begin
               db_cnt_r[i] <= '0;
            end else if (db_cnt_r[i] != DB_MAX) begin
               db_cnt_r[i] <= db_cnt_r[i] + 1'b1;
            end else begin
               db_cnt_r[i] <= db_cnt_r[i];
            end
            at_max_r[i] <= (db_cnt_r[i] == DB_MAX);
            ev_r[i]     <= (db_cnt_r[i] == DB_MAX) && !at_max_r[i] && prev_r[i];
         end
      end
   end

   // Same-cycle events resolve as clear > enter > digit
   assign clr_ev_s = ev_r[2];
   assign ent_ev_s = ev_r[1] & ~ev_r[2];
   assign dig_ev_s = ev_r[0] & ~ev_r[1] & ~ev_r[2];

   // Entry FSM: next state and next values of all datapath registers
   always_comb begin
      state_next_s  = state_r;
      digits_next_s = digits_r;
      count_next_s  = count_r;
      code_next_s   = code_r;
      len_next_s    = len_r;
      valid_next_s  = valid_r;
      ovf_next_s    = ovf_r;
`ifdef ENTRY_TIMEOUT_EN
      idle_next_s   = '0;
      tmo_next_s    = 1'b0;
`endif
      case (state_r)
         ST_IDLE: begin
            if (dig_ev_s) begin
               digits_next_s = CODE_W'(switches);
               count_next_s  = LEN_W'(1);
               ovf_next_s    = 1'b0;
               state_next_s  = ST_COLLECT;
            end else begin
               // Empty codes are never presented; clear has nothing to clear
               state_next_s = ST_IDLE;
            end
         end
         ST_COLLECT: begin
            if (clr_ev_s) begin
               digits_next_s = '0;
               count_next_s  = '0;
               ovf_next_s    = 1'b0;
               state_next_s  = ST_IDLE;
            end else if (ent_ev_s) begin
               code_next_s  = digits_r;
               len_next_s   = count_r;
               valid_next_s = 1'b1;
               state_next_s = ST_PRESENT;
            end else if (dig_ev_s) begin
               if (count_r < LEN_MAX) begin
                  digits_next_s = (digits_r << DIGIT_W) | CODE_W'(switches);
                  count_next_s  = count_r + 1'b1;
               end else begin
                  ovf_next_s = 1'b1;
               end
            end else begin
`ifdef ENTRY_TIMEOUT_EN
               if (idle_r == TMO_LAST) begin
                  digits_next_s = '0;
                  count_next_s  = '0;
                  ovf_next_s    = 1'b0;
                  tmo_next_s    = 1'b1;
                  state_next_s  = ST_IDLE;
               end else begin
                  idle_next_s = idle_r + 1'b1;
               end
`else
               state_next_s = ST_COLLECT;
`endif
            end
         end
         ST_PRESENT: begin
            // Buttons are ignored here so code_out/code_len stay stable
            if (cif.code_ack && valid_r) begin
               valid_next_s  = 1'b0;
               digits_next_s = '0;
               count_next_s  = '0;
               ovf_next_s    = 1'b0;
               state_next_s  = ST_IDLE;
            end else begin
               valid_next_s = valid_r;
            end
         end
         default: begin
            digits_next_s = '0;
            count_next_s  = '0;
            valid_next_s  = 1'b0;
            ovf_next_s    = 1'b0;
            state_next_s  = ST_IDLE;
         end
      endcase
   end

   // FSM state, datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         digits_r <= '0;
         count_r  <= '0;
         code_r   <= '0;
         len_r    <= '0;
         valid_r  <= 1'b0;
         ovf_r    <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_next_s;
         digits_r <= digits_next_s;
         count_r  <= count_next_s;
         code_r   <= code_next_s;
         len_r    <= len_next_s;
         valid_r  <= valid_next_s;
         ovf_r    <= ovf_next_s;
         busy_r   <= (state_next_s != ST_IDLE);
      end
   end

`ifdef ENTRY_TIMEOUT_EN
   // Idle counter and auto-clear pulse for abandoned entries
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_r <= '0;
         tmo_r  <= 1'b0;
      end else begin
         idle_r <= idle_next_s;
         tmo_r  <= tmo_next_s;
      end
   end

   assign timeout = tmo_r;
`else
   assign timeout = 1'b0;
`endif

   assign cif.code_out   = code_r;
   assign cif.code_len   = len_r;
   assign cif.code_valid = valid_r;
   assign busy           = busy_r;
   assign overflow       = ovf_r;

endmodule
